// File: rtl/axis_slave_rx_pkg.sv
// Shared AXI-Stream definitions: framing FSM encoding and packet-length width.
package axis_slave_rx_pkg;

  // Framing state encoding, kept identical to the master side.
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } rx_state_t;

  // Width of the per-packet beat counter and the reported packet length.
  localparam int PKT_LEN_W = 8;

  // Width of the optional completed-packet counter.
  localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/axis_rx_fifo.sv
// Receive buffer: DEPTH-entry FIFO, combinational head read, holds last head when empty.
module axis_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic [WIDTH-1:0] hold;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // The head is visible the cycle after it is written; when empty the last head is held.
  assign rdata = empty ? hold : mem[rd_ptr];

  // Storage write; entries carry no reset since occupancy tracks validity.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Pointer/occupancy bookkeeping; pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      hold   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (!empty) begin
        hold <= mem[rd_ptr];
      end
    end
  end

endmodule

// File: rtl/axis_slave_rx.sv
// AXI-Stream slave receiver: buffers beats, tracks packet framing and reports packet lengths.
// Optional feature: define AXIS_RX_PKT_CNT_EN to add the 16-bit completed-packet counter pkt_cnt.
module axis_slave_rx
  import axis_slave_rx_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DATA_W-1:0]    s_axis_tdata,
  input  logic                 s_axis_tvalid,
  input  logic                 s_axis_tlast,
  output logic                 s_axis_tready,
  output logic [DATA_W-1:0]    dout,
  output logic                 dout_valid,
  output logic                 dout_last,
  input  logic                 dout_ready,
  output logic                 pkt_done,
  output logic [PKT_LEN_W-1:0] pkt_len,
  output logic                 in_pkt
`ifdef AXIS_RX_PKT_CNT_EN
  ,
  output logic [PKT_CNT_W-1:0] pkt_cnt
`endif
);

  logic                 rdy_q;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_W:0]      head;
  logic                 accept;
  logic                 pop;
  rx_state_t            state_q;
  rx_state_t            state_d;
  logic [PKT_LEN_W-1:0] beat_cnt;
  logic [PKT_LEN_W-1:0] beat_inc;

  function automatic logic [PKT_LEN_W-1:0] sat_inc(input logic [PKT_LEN_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  // rdy_q keeps tready low through reset and for the edge that releases it.
  assign s_axis_tready = rdy_q & ~fifo_full;
  assign accept        = s_axis_tvalid & s_axis_tready;
  assign pop           = dout_valid & dout_ready;
  assign dout_valid    = ~fifo_empty;
  assign dout          = head[DATA_W-1:0];
  assign dout_last     = head[DATA_W] & ~fifo_empty;
  assign in_pkt        = (state_q == ST_IN_PKT);
  assign beat_inc      = sat_inc(beat_cnt);

  axis_rx_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .wdata ({s_axis_tlast, s_axis_tdata}),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Framing state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Framing next state: only accepted beats move the FSM; a tlast beat always lands in IDLE.
  always_comb begin
    state_d = state_q;
    if (accept) begin
      state_d = s_axis_tlast ? ST_IDLE : ST_IN_PKT;
    end
  end

  // Ready enable, beat counter and registered packet-completion report.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdy_q    <= 1'b0;
      beat_cnt <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
    end else begin
      rdy_q    <= 1'b1;
      pkt_done <= 1'b0;
      if (accept) begin
        if (s_axis_tlast) begin
          beat_cnt <= '0;
          pkt_done <= 1'b1;
          pkt_len  <= beat_inc;
        end else begin
          beat_cnt <= beat_inc;
        end
      end
    end
  end

`ifdef AXIS_RX_PKT_CNT_EN
  // Completed-packet counter, advancing with each pkt_done pulse and wrapping at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt <= '0;
    end else if (pkt_done) begin
      pkt_cnt <= pkt_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_axis_slave_rx.sv
// Testbench for axis_slave_rx: randomized traffic against a queue-based reference model,
// plus literal checks for reset release, single-beat, backpressure, saturation and mid-packet reset.
module tb_axis_slave_rx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [DATA_W-1:0] s_axis_tdata = '0;
  logic              s_axis_tvalid = 1'b0;
  logic              s_axis_tlast = 1'b0;
  logic              s_axis_tready;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_last;
  logic              dout_ready = 1'b0;
  logic              pkt_done;
  logic [7:0]        pkt_len;
  logic              in_pkt;
`ifdef AXIS_RX_PKT_CNT_EN
  logic [15:0]       pkt_cnt;
`endif

  axis_slave_rx #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .dout_last     (dout_last),
    .dout_ready    (dout_ready),
    .pkt_done      (pkt_done),
    .pkt_len       (pkt_len),
    .in_pkt        (in_pkt)
`ifdef AXIS_RX_PKT_CNT_EN
    ,
    .pkt_cnt       (pkt_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state: buffer contents as a queue of {last,data}, framing as plain counters.
  logic [8:0] mq[$];
  bit         m_rdy   = 0;
  logic [7:0] m_hold  = 0;
  int         m_cnt   = 0;
  int         m_len   = 0;
  bit         m_inpkt = 0;
  bit         m_done  = 0;
  int         m_pcnt  = 0;
  bit         m_live  = 0;

  always @(posedge clk) begin
    bit acc;
    bit pp;
    if (rst) begin
      mq.delete();
      m_rdy = 0; m_hold = 0; m_cnt = 0; m_len = 0;
      m_inpkt = 0; m_done = 0; m_pcnt = 0;
    end else begin
      acc = s_axis_tvalid && m_rdy && (mq.size() < DEPTH);
      pp  = dout_ready && (mq.size() > 0);
      m_done = 0;
      if (pp) begin
        m_hold = mq[0][7:0];
        void'(mq.pop_front());
      end
      if (acc) begin
        mq.push_back({s_axis_tlast, s_axis_tdata});
        if (s_axis_tlast) begin
          m_len   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_cnt   = 0;
          m_inpkt = 0;
          m_done  = 1;
          m_pcnt  = (m_pcnt + 1) % 65536;
        end else begin
          m_cnt   = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
          m_inpkt = 1;
        end
      end
      m_rdy = 1;
    end
    m_live = 1;
  end

  // Per-cycle comparison of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_live) begin
      check("tready", 32'(s_axis_tready), 32'(m_rdy && (mq.size() < DEPTH)));
      check("dout_valid", 32'(dout_valid), 32'(mq.size() > 0));
      check("dout", 32'(dout), 32'((mq.size() > 0) ? mq[0][7:0] : m_hold));
      if (mq.size() > 0) check("dout_last", 32'(dout_last), 32'(mq[0][8]));
      check("pkt_done", 32'(pkt_done), 32'(m_done));
      check("pkt_len", 32'(pkt_len), 32'(m_len));
      check("in_pkt", 32'(in_pkt), 32'(m_inpkt));
`ifdef AXIS_RX_PKT_CNT_EN
      check("pkt_cnt", 32'(pkt_cnt), 32'(m_pcnt));
`endif
    end
  end

  // Observed packet reports, used by the literal expectations.
  int         seen_done = 0;
  logic [7:0] seen_len  = 0;
  always @(negedge clk) begin
    if (m_live && pkt_done === 1'b1) begin
      seen_done++;
      seen_len = pkt_len;
    end
  end

  // Consumer: forced level or random toggling.
  bit rnd_mode  = 0;
  bit rdy_force = 0;
  always @(posedge clk) begin
    #3;
    dout_ready = rnd_mode ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_beat(input logic [7:0] d, input logic l, input int gap);
    bit acc;
    bit ok;
    repeat (gap) tick();
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      acc = s_axis_tready;
      tick();
      if (acc) begin
        ok = 1;
        break;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    if (!ok) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: beat %0h never accepted", d);
    end
  endtask

  initial begin
    int d0;
    int c0;

    // Reset held, then released.
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("rst_tready", 32'(s_axis_tready), 32'd0);
    check("rst_dout", 32'(dout), 32'd0);
    check("rst_dout_last", 32'(dout_last), 32'd0);
    check("rst_pkt_len", 32'(pkt_len), 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rel_tready_pre", 32'(s_axis_tready), 32'd0);
    @(negedge clk);
    check("rel_tready", 32'(s_axis_tready), 32'd1);
    check("rel_dout_valid", 32'(dout_valid), 32'd0);
    check("rel_pkt_len", 32'(pkt_len), 32'd0);
    tick();

    // Single-beat packet.
    rdy_force = 1;
    tick();
    send_beat(8'h0A, 1'b1, 0);
    @(negedge clk);
    check("sb_dout", 32'(dout), 32'h0A);
    check("sb_dout_last", 32'(dout_last), 32'd1);
    check("sb_pkt_done", 32'(pkt_done), 32'd1);
    check("sb_pkt_len", 32'(pkt_len), 32'd1);
    check("sb_in_pkt", 32'(in_pkt), 32'd0);
    tick();

    // Backpressure: four beats fill the buffer, fifth waits until the consumer drains.
    rdy_force = 0;
    repeat (3) tick();
    for (int i = 0; i < 4; i++) send_beat(8'(i), 1'b0, 0);
    @(negedge clk);
    check("bp_tready_full", 32'(s_axis_tready), 32'd0);
    check("bp_head", 32'(dout), 32'd0);
    tick();
    fork
      send_beat(8'd4, 1'b1, 0);
      begin
        repeat (3) tick();
        @(negedge clk);
        check("bp_tready_held", 32'(s_axis_tready), 32'd0);
        tick();
        rdy_force = 1;
      end
    join
    repeat (10) tick();
    check("bp_pkt_len", 32'(seen_len), 32'd5);

    // Ten-beat packet with random small data and random consumer.
    rnd_mode = 1;
    d0 = seen_done;
    for (int i = 1; i <= 10; i++) begin
      send_beat(8'($urandom_range(0, 15)), (i == 10), $urandom_range(0, 1));
      if (i == 9) begin
        @(negedge clk);
        check("p10_in_pkt", 32'(in_pkt), 32'd1);
        tick();
      end
    end
    rnd_mode = 0;
    rdy_force = 1;
    repeat (10) tick();
    check("p10_pkt_len", 32'(seen_len), 32'd10);
    check("p10_done_cnt", 32'(seen_done - d0), 32'd1);

    // 300-beat packet saturates the reported length.
`ifdef AXIS_RX_PKT_CNT_EN
    c0 = int'(pkt_cnt);
`else
    c0 = 0;
`endif
    for (int i = 0; i < 300; i++) send_beat(8'($urandom), (i == 299), 0);
    repeat (10) tick();
    check("p300_pkt_len", 32'(seen_len), 32'd255);
`ifdef AXIS_RX_PKT_CNT_EN
    check("p300_pkt_cnt", 32'(pkt_cnt), 32'((c0 + 1) % 65536));
`endif

    // Reset in the middle of a packet discards it without a report.
    rdy_force = 0;
    repeat (2) tick();
    for (int i = 0; i < 3; i++) send_beat(8'(8'h30 + i), 1'b0, 0);
    d0 = seen_done;
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("mr_dout_valid", 32'(dout_valid), 32'd0);
    check("mr_in_pkt", 32'(in_pkt), 32'd0);
    check("mr_pkt_done", 32'(pkt_done), 32'd0);
    tick();
    rst = 1'b0;
    rdy_force = 1;
    repeat (2) tick();
    check("mr_no_done", 32'(seen_done - d0), 32'd0);
    for (int i = 0; i < 5; i++) send_beat(8'(8'h50 + i), (i == 4), 0);
    repeat (6) tick();
    check("mr_next_len", 32'(seen_len), 32'd5);

    // Random packets with random gaps and random consumer.
    rnd_mode = 1;
    d0 = seen_done;
    for (int p = 0; p < 15; p++) begin
      int len;
      len = $urandom_range(1, 12);
      for (int b = 0; b < len; b++) send_beat(8'($urandom), (b == len - 1), $urandom_range(0, 2));
    end
    rnd_mode = 0;
    rdy_force = 1;
    repeat (12) tick();
    check("rnd_done_cnt", 32'(seen_done - d0), 32'd15);
    check("rnd_drained", 32'(dout_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
